// File: rtl/im_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the combinational IM and feeds decode via a 1-entry slot.
// Latency pc -> if_valid 1 cycle; slot holds under !if_ready; FETCH_PERF_EN enables perf_fetch/perf_stall.
module im_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NMEM     = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        fault,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [29:0] NMEM_W = 30'(NMEM);

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] ipc_q;
    logic        halted_q;
    logic        fault_q;

    logic slot_free;
    logic in_range;
    logic redir_take;
    logic redir_bad;
    logic issue;

    assign slot_free  = !valid_q || if_ready;
    assign in_range   = (pc_q[31:2] < NMEM_W) && (pc_q[1:0] == 2'b00);
    assign redir_take = redir_valid && (state_q != ST_FAULT);
    assign redir_bad  = (redir_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redir_take) begin
            state_d = redir_bad ? ST_FAULT : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (slot_free && !in_range) begin
                        state_d = ST_FAULT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // A pending halt suppresses the fetch in the same cycle it is requested.
    always_comb begin
        issue    = !redir_take && (state_q == ST_RUN) && !halt_req && slot_free && in_range;
        im_addr  = pc_q;
        if_valid = valid_q;
        if_instr = instr_q;
        if_pc    = ipc_q;
        halted   = halted_q;
        fault    = fault_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            ipc_q    <= 32'h0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            halted_q <= (state_d == ST_HALT);
            fault_q  <= (state_d == ST_FAULT);
            if (redir_take) begin
                valid_q <= 1'b0;
                if (!redir_bad) begin
                    pc_q <= redir_pc;
                end
            end else if (issue) begin
                instr_q <= im_data;
                ipc_q   <= pc_q;
                valid_q <= 1'b1;
                pc_q    <= pc_q + 32'd4;
            end else if (slot_free) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    // A word accepted in the same cycle as a redirect is flushed, so it is not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            if (valid_q && if_ready && !redir_take) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (valid_q && !if_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_fetch = 32'h0;
    assign perf_stall = 32'h0;
`endif

endmodule
